gate_chain_accumulator: RTL and testbench



---
 rtl/gate_chain_accumulator_pkg.sv | 26 ++
 rtl/gate_chain_accumulator_if.sv | 32 +++
 rtl/gate_chain_accumulator.sv | 134 +++++++++++++
 tb/tb_gate_chain_accumulator.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_chain_accumulator_pkg.sv
// Shared fixed-point complex 2x2 matrix types for the quantum-gate datapath.
// Also holds the accumulator FSM state encoding.
package qsim_pkg;

  localparam int CFX_W = 37;

  typedef logic signed [CFX_W-1:0] cfx_t;
  typedef cfx_t [0:1][0:1][0:1] cmtx_t;  // [row][col][0=re,1=im]

  typedef enum logic [2:0] {
    ACCEPT,
    ISSUE,
    WAIT,
    DRAIN,
    OUTPUT
  } gca_state_t;

  function automatic cmtx_t cmtx_identity(input int frac_bits);
    cmtx_t m;
    m = '0;
    m[0][0][0] = cfx_t'(64'sd1 << frac_bits);
    m[1][1][0] = cfx_t'(64'sd1 << frac_bits);
    return m;
  endfunction

endpackage

// File: rtl/gate_chain_accumulator_if.sv
// Gate stream, multiplier link and result stream of the gate chain accumulator.
// master = accumulator side, slave = surrounding environment.
interface gate_chain_accumulator_if
  import qsim_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic             gate_valid;
  logic             gate_last;
  cmtx_t            gate_mtx;
  logic             gate_ready;
  cmtx_t            mul_a;
  cmtx_t            mul_b;
  logic             mul_start;
  cmtx_t            mul_r;
  logic             mul_done;
  logic             res_valid;
  logic             res_ready;
  cmtx_t            res_mtx;
  logic [CNT_W-1:0] res_count;
  logic             res_timeout;

  modport master (
    input  gate_valid, gate_last, gate_mtx, mul_r, mul_done, res_ready,
    output gate_ready, mul_a, mul_b, mul_start, res_valid, res_mtx, res_count, res_timeout
  );

  modport slave (
    output gate_valid, gate_last, gate_mtx, mul_r, mul_done, res_ready,
    input  gate_ready, mul_a, mul_b, mul_start, res_valid, res_mtx, res_count, res_timeout
  );
endinterface

// File: rtl/gate_chain_accumulator.sv
// Folds a stream of 2x2 complex gates into U = Gn*...*G1 by driving an external
// complex matrix multiplier; one result per gate_last-terminated sequence.
module gate_chain_accumulator
  import qsim_pkg::*;
#(
  parameter int FRAC_BITS = 34,
  parameter int TIMEOUT   = 64,
  parameter int CNT_W     = 16
) (
  input logic                      clk,
  input logic                      reset_n,
  gate_chain_accumulator_if.master bus
);

  localparam int    TO_W  = $clog2(TIMEOUT + 1);
  localparam cmtx_t IDENT = cmtx_identity(FRAC_BITS);

  gca_state_t       state;
  cmtx_t            u_mtx;
  cmtx_t            g_mtx;
  logic             last_q;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;
  logic [TO_W-1:0]  tcnt;
  logic             err;
  logic             gate_ready;
  logic             mul_start;
  logic             res_valid;
  logic [CNT_W-1:0] res_count;
  logic             res_timeout;

  always_comb begin
    count_inc = (&count) ? count : count + 1'b1;
  end

  // G and U stay put outside ACCEPT/WAIT so the multiplier sees stable operands
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ACCEPT;
      u_mtx       <= IDENT;
      g_mtx       <= '0;
      last_q      <= 1'b0;
      count       <= '0;
      tcnt        <= '0;
      err         <= 1'b0;
      gate_ready  <= 1'b0;
      mul_start   <= 1'b0;
      res_valid   <= 1'b0;
      res_count   <= '0;
      res_timeout <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      case (state)
        ACCEPT: begin
          gate_ready <= 1'b1;
          if (bus.gate_valid && gate_ready) begin
            g_mtx      <= bus.gate_mtx;
            last_q     <= bus.gate_last;
            gate_ready <= 1'b0;
            mul_start  <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          tcnt  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (bus.mul_done) begin
            u_mtx <= bus.mul_r;
            count <= count_inc;
            if (last_q) begin
              res_valid   <= 1'b1;
              res_count   <= count_inc;
              res_timeout <= err;
              state       <= OUTPUT;
            end else begin
              gate_ready <= 1'b1;
              state      <= ACCEPT;
            end
          end else if (tcnt == TO_W'(TIMEOUT - 1)) begin
            err <= 1'b1;
            if (last_q) begin
              res_valid   <= 1'b1;
              res_count   <= count;
              res_timeout <= 1'b1;
              state       <= OUTPUT;
            end else begin
              gate_ready <= 1'b1;
              state      <= DRAIN;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        DRAIN: begin
          // Remaining gates of an aborted sequence are swallowed up to gate_last
          gate_ready <= 1'b1;
          if (bus.gate_valid && gate_ready && bus.gate_last) begin
            gate_ready  <= 1'b0;
            res_valid   <= 1'b1;
            res_count   <= count;
            res_timeout <= err;
            state       <= OUTPUT;
          end
        end
        OUTPUT: begin
          gate_ready <= 1'b0;
          if (res_valid && bus.res_ready) begin
            u_mtx       <= IDENT;
            count       <= '0;
            err         <= 1'b0;
            res_valid   <= 1'b0;
            res_count   <= '0;
            res_timeout <= 1'b0;
            gate_ready  <= 1'b1;
            state       <= ACCEPT;
          end
        end
        default: state <= ACCEPT;
      endcase
    end
  end

  assign bus.gate_ready  = gate_ready;
  assign bus.mul_start   = mul_start;
  assign bus.mul_a       = g_mtx;
  assign bus.mul_b       = u_mtx;
  assign bus.res_mtx     = u_mtx;
  assign bus.res_valid   = res_valid;
  assign bus.res_count   = res_count;
  assign bus.res_timeout = res_timeout;

endmodule

// File: tb/tb_gate_chain_accumulator.sv
// Scoreboard bench for gate_chain_accumulator with a behavioural 2-cycle multiplier.
module tb_gate_chain_accumulator;
  import qsim_pkg::*;

  localparam int FRAC = 34;
  localparam int TO   = 8;
  localparam int CW   = 16;
  localparam cfx_t ONE  = 37'sh4_0000_0000;
  localparam cfx_t MONE = -37'sh4_0000_0000;

  typedef struct {
    cmtx_t          m;
    logic [CW-1:0]  c;
    logic           t;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  gate_chain_accumulator_if #(.CNT_W(CW)) bus ();

  gate_chain_accumulator #(.FRAC_BITS(FRAC), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  logic mul_en = 1'b1;
  logic stray  = 1'b0;
  logic hold   = 1'b0;
  logic d1 = 1'b0;
  logic dq = 1'b0;

  function automatic cmtx_t cmul(cmtx_t a, cmtx_t b);
    cmtx_t r;
    logic signed [79:0] re, im;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        re = '0;
        im = '0;
        for (int k = 0; k < 2; k++) begin
          re = re + 80'(a[i][k][0]) * 80'(b[k][j][0]) - 80'(a[i][k][1]) * 80'(b[k][j][1]);
          im = im + 80'(a[i][k][0]) * 80'(b[k][j][1]) + 80'(a[i][k][1]) * 80'(b[k][j][0]);
        end
        r[i][j][0] = cfx_t'(re >>> FRAC);
        r[i][j][1] = cfx_t'(im >>> FRAC);
      end
    return r;
  endfunction

  // Multiplier model: completed two cycles after the start pulse
  always @(posedge clk) begin
    d1 <= bus.mul_start & mul_en;
    dq <= d1;
  end
  assign bus.mul_done  = dq | stray;
  assign bus.mul_r     = cmul(bus.mul_a, bus.mul_b);
  assign bus.res_ready = ~hold;

  task automatic chk(input string name, input logic [295:0] act, input logic [295:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push(input cmtx_t m, input int c, input logic t);
    exp_t e;
    e.m = m;
    e.c = CW'(c);
    e.t = t;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (bus.res_valid && bus.res_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=1 required=0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_mtx", 296'(bus.res_mtx), 296'(e.m));
        chk("res_count", 296'(bus.res_count), 296'(e.c));
        chk("res_timeout", 296'(bus.res_timeout), 296'(e.t));
      end
    end
  end

  task automatic send(input cmtx_t m, input logic last);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.gate_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.gate_ready) begin
      checks++;
      errors++;
      $display("FAIL gate_ready_timeout actual=0 required=1");
      return;
    end
    bus.gate_valid = 1'b1;
    bus.gate_mtx   = m;
    bus.gate_last  = last;
    @(negedge clk);
    bus.gate_valid = 1'b0;
    bus.gate_last  = 1'b0;
  endtask

  task automatic drain_sb();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL result_timeout actual=%0d required=0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  cmtx_t mx, mz, ms, mzx, mid;

  initial begin
    int n;
    mid = cmtx_identity(FRAC);
    mx = '0;  mx[0][1][0] = ONE;  mx[1][0][0] = ONE;
    mz = '0;  mz[0][0][0] = ONE;  mz[1][1][0] = MONE;
    ms = '0;  ms[0][0][0] = ONE;  ms[1][1][1] = ONE;
    mzx = '0; mzx[0][1][0] = ONE; mzx[1][0][0] = MONE;

    bus.gate_valid = 1'b0;
    bus.gate_last  = 1'b0;
    bus.gate_mtx   = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_gate_ready", 296'(bus.gate_ready), 296'(1'b0));
    chk("rst_res_valid", 296'(bus.res_valid), 296'(1'b0));
    chk("rst_mul_start", 296'(bus.mul_start), 296'(1'b0));
    chk("rst_res_count", 296'(bus.res_count), 296'(0));
    chk("rst_res_mtx", 296'(bus.res_mtx), 296'(mid));
    chk("rst_mul_a", 296'(bus.mul_a), 296'(0));
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_gate_ready", 296'(bus.gate_ready), 296'(1'b1));

    // Single X
    push(mx, 1, 1'b0);
    send(mx, 1'b1);
    drain_sb();

    // X then X -> identity
    push(mid, 2, 1'b0);
    send(mx, 1'b0);
    send(mx, 1'b1);
    drain_sb();

    // Order: Z*X, then S*S = Z through the imaginary path
    push(mzx, 2, 1'b0);
    send(mx, 1'b0);
    send(mz, 1'b1);
    drain_sb();
    push(mz, 2, 1'b0);
    send(ms, 1'b0);
    send(ms, 1'b1);
    drain_sb();

    // Backpressure on the result
    hold = 1'b1;
    push(mx, 1, 1'b0);
    send(mx, 1'b1);
    n = 0;
    while (!bus.res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (10) begin
      @(negedge clk);
      chk("hold_res_valid", 296'(bus.res_valid), 296'(1'b1));
      chk("hold_res_mtx", 296'(bus.res_mtx), 296'(mx));
      chk("hold_res_count", 296'(bus.res_count), 296'(1));
      chk("hold_gate_ready", 296'(bus.gate_ready), 296'(1'b0));
    end
    @(posedge clk);
    #1 hold = 1'b0;
    drain_sb();
    push(mz, 1, 1'b0);
    send(mz, 1'b1);
    drain_sb();

    // Multiplier never completes: timeout then drain
    mul_en = 1'b0;
    push(mid, 0, 1'b1);
    send(mx, 1'b0);
    send(mx, 1'b0);
    send(mx, 1'b1);
    drain_sb();
    mul_en = 1'b1;

    // Reset while waiting on the multiplier, then a stray done
    send(mx, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_gate_ready", 296'(bus.gate_ready), 296'(1'b0));
    chk("mid_rst_mul_start", 296'(bus.mul_start), 296'(1'b0));
    chk("mid_rst_res_valid", 296'(bus.res_valid), 296'(1'b0));
    chk("mid_rst_res_mtx", 296'(bus.res_mtx), 296'(mid));
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    @(negedge clk);
    chk("stray_res_valid", 296'(bus.res_valid), 296'(1'b0));
    chk("stray_gate_ready", 296'(bus.gate_ready), 296'(1'b1));
    chk("stray_mul_start", 296'(bus.mul_start), 296'(1'b0));
    chk("stray_res_mtx", 296'(bus.res_mtx), 296'(mid));
    push(mz, 1, 1'b0);
    send(mz, 1'b1);
    drain_sb();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
